// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared state type and counter width for the scratch-RAM
//               strobe controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ram_ctrl_state_t;

    localparam int STROBE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// ============================================================================
// Module      : ram_access_ctrl
// Description : Sequences single load/store requests into setup, strobe and
//               hold phases on a 1-bit scratch-RAM port; one-cycle response.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int WORD          = 1,
    parameter int SIZE_LOG      = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [SIZE_LOG-1:0] req_addr,
    input  logic [WORD-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [WORD-1:0]     rsp_rdata,
    output logic                ram_read,
    output logic                ram_write,
    output logic [SIZE_LOG-1:0] ram_address,
    output logic [WORD-1:0]     ram_wdata,
    input  logic [WORD-1:0]     ram_rdata
);

    generate
        if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe_cycles
            $error("ram_access_ctrl: STROBE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [STROBE_CNT_W-1:0] c_strobe_load = STROBE_CNT_W'(STROBE_CYCLES - 1);

    ram_ctrl_state_t            state_q, state_d;
    logic [STROBE_CNT_W-1:0]    cnt_q, cnt_d;
    logic                       we_q, we_d;
    logic [SIZE_LOG-1:0]        ram_address_q, ram_address_d;
    logic [WORD-1:0]            ram_wdata_q, ram_wdata_d;
    logic                       ram_read_q, ram_read_d;
    logic                       ram_write_q, ram_write_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [WORD-1:0]            rsp_rdata_q, rsp_rdata_d;
    logic                       w_accept;

    // Ready is forced low during reset so no request is taken while the port is held.
    assign req_ready = reset_n && ((state_q == IDLE) || (state_q == HOLD));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;

        case (state_q)
            IDLE, HOLD: begin
                // Capturing straight into the port registers keeps the old
                // address stable through HOLD; the new one shows in SETUP.
                if (w_accept) begin
                    state_d       = SETUP;
                    we_d          = req_we;
                    ram_address_d = req_addr;
                    ram_wdata_d   = req_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d     = STROBE;
                cnt_d       = c_strobe_load;
                ram_read_d  = !we_q;
                ram_write_d = we_q;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : ram_rdata;
                end else begin
                    cnt_d       = cnt_q - STROBE_CNT_W'(1);
                    ram_read_d  = ram_read_q;
                    ram_write_d = ram_write_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// ============================================================================
// Module      : tb_ram_access_ctrl
// Description : Self-checking bench for ram_access_ctrl with a RAM model and
//               a transaction-level expectation of each access.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_access_ctrl;

    localparam int WORD     = 1;
    localparam int SIZE_LOG = 8;
    localparam int S        = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [SIZE_LOG-1:0] req_addr;
    logic [WORD-1:0]     req_wdata;
    logic                rsp_valid;
    logic [WORD-1:0]     rsp_rdata;
    logic                ram_read;
    logic                ram_write;
    logic [SIZE_LOG-1:0] ram_address;
    logic [WORD-1:0]     ram_wdata;
    logic [WORD-1:0]     ram_rdata;

    logic [WORD-1:0]     ram_mem   [0:(1<<SIZE_LOG)-1];
    logic [WORD-1:0]     model_mem [0:(1<<SIZE_LOG)-1];

    int                  checks   = 0;
    int                  failures = 0;
    logic [SIZE_LOG-1:0] last_addr  = '0;
    logic [WORD-1:0]     last_wdata = '0;

    ram_access_ctrl #(
        .WORD          (WORD),
        .SIZE_LOG      (SIZE_LOG),
        .STROBE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM device model: combinational read, write on an edge with the strobe high.
    assign ram_rdata = ram_mem[ram_address];
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_address] <= ram_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = SIZE_LOG'($urandom);
        req_wdata = WORD'($urandom);
    endtask

    // Called at a falling edge while the controller is in IDLE or HOLD.
    task automatic access(input logic we, input logic [SIZE_LOG-1:0] addr, input logic [WORD-1:0] wdata);
        logic [WORD-1:0] exp_rdata;
        exp_rdata = we ? '0 : model_mem[addr];
        check("ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        check("setup_addr",   ram_address, addr);
        check("setup_wdata",  ram_wdata, wdata);
        check("setup_read",   ram_read, 0);
        check("setup_write",  ram_write, 0);
        check("setup_ready",  req_ready, 0);
        check("setup_rsp",    rsp_valid, 0);
        scramble_req();
        for (int k = 0; k < S; k++) begin
            @(negedge clk);
            check("strobe_write", ram_write, we);
            check("strobe_read",  ram_read, !we);
            check("strobe_addr",  ram_address, addr);
            check("strobe_wdata", ram_wdata, wdata);
            check("strobe_ready", req_ready, 0);
            check("strobe_rsp",   rsp_valid, 0);
            scramble_req();
        end
        @(negedge clk);
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_rdata", rsp_rdata, exp_rdata);
        check("hold_read",      ram_read, 0);
        check("hold_write",     ram_write, 0);
        check("hold_addr",      ram_address, addr);
        check("hold_wdata",     ram_wdata, wdata);
        check("hold_ready",     req_ready, 1);
        if (we) model_mem[addr] = wdata;
        last_addr  = addr;
        last_wdata = wdata;
        req_valid  = 1'b0;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_rsp",   rsp_valid, 0);
        check("idle_read",  ram_read, 0);
        check("idle_write", ram_write, 0);
        check("idle_ready", req_ready, 1);
        check("idle_addr",  ram_address, last_addr);
        check("idle_wdata", ram_wdata, last_wdata);
    endtask

    initial begin
        for (int i = 0; i < (1 << SIZE_LOG); i++) begin
            ram_mem[i]   = WORD'($urandom);
            model_mem[i] = ram_mem[i];
        end
        ram_mem[8'h5A]   = '0;
        model_mem[8'h5A] = '0;

        // Reset held for three clocks with a request pending.
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'hC3;
        req_wdata = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready",     req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_read",      ram_read, 0);
            check("rst_write",     ram_write, 0);
            check("rst_addr",      ram_address, 0);
            check("rst_wdata",     ram_wdata, 0);
        end
        reset_n = 1'b1;
        #1;
        check("ready_after_release", req_ready, 1);

        // Store then load the same location, then back-to-back across the address range ends.
        access(1'b1, 8'h5A, 1'b1);
        idle_cycle();
        access(1'b0, 8'h5A, 1'b0);
        idle_cycle();
        access(1'b1, 8'hFF, 1'b1);
        access(1'b0, 8'h00, 1'b0);
        access(1'b0, 8'hFF, 1'b0);
        idle_cycle();

        // Reset asserted while the write strobe is high.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h33;
        req_wdata = ~model_mem[8'h33];
        check("ready_before_abort", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_write_high", ram_write, 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_write_drop", ram_write, 0);
        check("abort_read",       ram_read, 0);
        check("abort_ready",      req_ready, 0);
        check("abort_addr",       ram_address, 0);
        @(negedge clk);
        check("abort_rsp", rsp_valid, 0);
        reset_n = 1'b1;
        #1;
        check("abort_ready_release", req_ready, 1);
        last_addr  = '0;
        last_wdata = '0;
        idle_cycle();
        access(1'b0, 8'h33, 1'b0);

        // Randomized mix of loads/stores with random gaps or back-to-back issue.
        for (int n = 0; n < 40; n++) begin
            logic                we;
            logic [SIZE_LOG-1:0] a;
            we = 1'($urandom_range(0, 1));
            a  = SIZE_LOG'($urandom_range(0, 7));
            if (n % 3 == 0) a = SIZE_LOG'($urandom);
            access(we, a, WORD'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cycle();
            end
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
